// File: rtl/piso_3bit_right_shift_transmitter.sv
// Parallel-in, serial-out transmitter: accepts a word over a valid/ready load
// handshake and shifts it out LSB first, one bit per enabled cycle, with a done pulse.
module piso_3bit_right_shift_transmitter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             bout,
    output logic             bout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] sr_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic             done_r;
    logic             done_s;

    // State, shift register, bit counter and done flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            sr_r    <= '0;
            cnt_r   <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            sr_r    <= sr_s;
            cnt_r   <= cnt_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; the done flag is a single-cycle pulse by default-clearing it.
    always_comb begin
        state_s = state_r;
        sr_s    = sr_r;
        cnt_s   = cnt_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (load_valid) begin
                    sr_s    = din;
                    cnt_s   = {CW{1'b0}};
                    state_s = SHIFT;
                end else begin
                    sr_s    = sr_r;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (cnt_r == LAST_IDX) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                        sr_s    = '0;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        sr_s  = {1'b0, sr_r[WIDTH-1:1]};
                        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    sr_s = sr_r;
                end
            end
            default: begin
                state_s = IDLE;
                sr_s    = '0;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Serial outputs are qualified by the state register so bout reads 0 when idle.
    always_comb begin
        busy       = (state_r == SHIFT);
        bout_valid = (state_r == SHIFT);
        bout       = sr_r[0] & (state_r == SHIFT);
        done       = done_r;
        load_ready = (state_r == IDLE) & rst;
    end

endmodule

// File: tb/tb_piso_3bit_right_shift_transmitter.sv
// Directed self-checking bench for the 3-bit PISO transmitter, including a
// loopback through a bench-side 3-bit right-shift register.
module tb_piso_3bit_right_shift_transmitter;

    logic       clk;
    logic       rst;
    logic [2:0] din;
    logic       load_valid;
    logic       load_ready;
    logic       shift_en;
    logic       bout;
    logic       bout_valid;
    logic       busy;
    logic       done;
    logic [2:0] siso_r;
    int         check_cnt;
    int         pass_cnt;

    piso_3bit_right_shift_transmitter #(.WIDTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .bout       (bout),
        .bout_valid (bout_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial consumer: input a enters at the MSB, output is the LSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) siso_r <= 3'b000;
        else      siso_r <= {bout, siso_r[2:1]};
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        check_cnt++;
        if (obs === exp_v) pass_cnt++;
        else $display("FAIL %s: observed %b required %b", tag, obs, exp_v);
    endtask

    // Compare the packed output vector {bout, bout_valid, busy, done, load_ready}.
    task automatic chk_out(input string tag, input logic [4:0] exp_v);
        chk(tag, {3'b000, bout, bout_valid, busy, done, load_ready}, {3'b000, exp_v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [4:0] O_IDLE  = 5'b00001;
    localparam logic [4:0] O_DONE  = 5'b00011;
    localparam logic [4:0] O_BIT0  = 5'b01100;
    localparam logic [4:0] O_BIT1  = 5'b11100;
    localparam logic [4:0] O_RESET = 5'b00000;

    initial begin
        check_cnt  = 0;
        pass_cnt   = 0;
        rst        = 1'b0;
        din        = 3'b111;
        load_valid = 1'b1;
        shift_en   = 1'b0;

        // Reset held for two cycles with a load offered.
        tick();
        chk_out("reset_c1", O_RESET);
        tick();
        chk_out("reset_c2", O_RESET);
        load_valid = 1'b0;
        rst        = 1'b1;
        #1;
        chk_out("reset_release", O_IDLE);
        tick();
        chk_out("idle_after_reset", O_IDLE);

        // Basic word 101.
        din = 3'b101; load_valid = 1'b1; shift_en = 1'b1;
        tick();
        load_valid = 1'b0;
        chk_out("basic_b0", O_BIT1);
        tick();
        chk_out("basic_b1", O_BIT0);
        tick();
        chk_out("basic_b2", O_BIT1);
        tick();
        chk_out("basic_done", O_DONE);
        tick();
        chk_out("basic_after", O_IDLE);

        // Stall on bit 1 of 110 with an ignored load attempt.
        din = 3'b110; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk_out("stall_b0", O_BIT0);
        tick();
        chk_out("stall_b1", O_BIT1);
        shift_en = 1'b0; load_valid = 1'b1; din = 3'b000;
        tick();
        chk_out("stall_hold1", O_BIT1);
        tick();
        chk_out("stall_hold2", O_BIT1);
        shift_en = 1'b1;
        tick();
        load_valid = 1'b0;
        chk_out("stall_b2", O_BIT1);
        tick();
        chk_out("stall_done", O_DONE);
        tick();
        chk_out("stall_after", O_IDLE);

        // Back-to-back words 011 then 100.
        din = 3'b011; load_valid = 1'b1;
        tick();
        chk_out("b2b_w0_b0", O_BIT1);
        tick();
        chk_out("b2b_w0_b1", O_BIT1);
        tick();
        chk_out("b2b_w0_b2", O_BIT0);
        tick();
        chk_out("b2b_done0", O_DONE);
        din = 3'b100;
        tick();
        chk_out("b2b_w1_b0", O_BIT0);
        tick();
        chk_out("b2b_w1_b1", O_BIT0);
        tick();
        load_valid = 1'b0;
        chk_out("b2b_w1_b2", O_BIT1);
        tick();
        chk_out("b2b_done1", O_DONE);
        tick();
        chk_out("b2b_after", O_IDLE);

        // Reset mid-word discards the word without a done pulse.
        din = 3'b111; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk_out("mid_b0", O_BIT1);
        #2;
        rst = 1'b0;
        #1;
        chk_out("mid_reset_now", O_RESET);
        tick();
        chk_out("mid_reset_hold", O_RESET);
        rst = 1'b1;
        tick();
        chk_out("mid_release", O_IDLE);
        tick();
        chk_out("mid_no_done", O_IDLE);
        din = 3'b010; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk_out("post_b0", O_BIT0);
        tick();
        chk_out("post_b1", O_BIT1);
        tick();
        chk_out("post_b2", O_BIT0);
        tick();
        chk_out("post_done", O_DONE);

        // Loopback of 101 through a 3-deep right shift: output delayed by 3 cycles.
        din = 3'b101; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("loop_q0", {7'b0, siso_r[0]}, 8'd1);
        tick();
        chk("loop_q1", {7'b0, siso_r[0]}, 8'd0);
        tick();
        chk("loop_q2", {7'b0, siso_r[0]}, 8'd1);
        tick();
        chk("loop_q3", {7'b0, siso_r[0]}, 8'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
